// File: rtl/seq_mult_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM state encodings
// and the default operand width.
package seq_mult_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_if.sv
// Request/result bundle between a requester and the sequential multiplier.
interface seq_mult_if
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic               start;
  logic               mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, mode, multiplicand, multiplier,
    output product, busy, done
  );

endinterface

// File: rtl/seq_mult_dp.sv
// Multiplier datapath: operand magnitude capture, shift-add accumulator and
// final sign restoration.
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result_c
);

  localparam int unsigned PW = 2 * WIDTH;

  // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? WIDTH'(~v + 1'b1) : v;
  endfunction

  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             neg_q;
  logic [PW-1:0]    acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
    end else if (load) begin
      mcand_q  <= PW'(magnitude(a, signed_op));
      mplier_q <= magnitude(b, signed_op);
      neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign result_c = neg_q ? PW'(~acc_q + 1'b1) : acc_q;

endmodule

// File: rtl/seq_mult.sv
// Sequential multiplier top: IDLE/CALC/DONE control, iteration counter and
// registered result/status outputs around the shift-add datapath.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_mult_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_c;
  logic            step_c;
  logic            signed_op_c;
  logic [PW-1:0]   result_c;
  logic [PW-1:0]   product_q;
  logic            busy_q;
  logic            done_q;

  assign signed_op_c = (SIGNED_EN != 0) && bus.mode;

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .step      (step_c),
    .signed_op (signed_op_c),
    .a         (bus.multiplicand),
    .b         (bus.multiplier),
    .result_c  (result_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The cycle with the counter at zero closes CALC and hands over to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          cnt_d   = CW'(WIDTH);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          step_c = 1'b1;
          cnt_d  = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          cnt_d   = CW'(WIDTH);
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Product only moves on DONE entry so partial sums never appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_d == ST_DONE);
      busy_q <= (state_d != ST_IDLE);
      if (state_d == ST_DONE) begin
        product_q <= result_c;
      end
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult: 4-bit signed-capable instance and
// an 8-bit unsigned-only instance.
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(4)) if4 ();
  seq_mult_if #(.WIDTH(8)) if8 ();

  seq_mult #(.WIDTH(4), .SIGNED_EN(1)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  seq_mult #(.WIDTH(8), .SIGNED_EN(0)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  logic [3:0] hold_a [3] = '{4'd2, 4'd4, 4'd6};
  logic [3:0] hold_b [3] = '{4'd3, 4'd5, 4'd7};
  logic [7:0] hold_p [3] = '{8'd6, 8'd20, 8'd42};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 4-bit operation: checks busy after acceptance, latency in edges and product.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic mode,
                      input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    if4.start        = 1'b1;
    if4.mode         = mode;
    if4.multiplicand = a;
    if4.multiplier   = b;
    tick();
    if4.start = 1'b0;
    chk({tag, "_busy"}, 32'(if4.busy), 32'd1);
    while (n < 20) begin
      tick();
      n++;
      if (if4.done) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'd5);
    chk({tag, "_prod"}, 32'(if4.product), 32'(exp));
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic mode,
                      input logic [15:0] exp, input string tag);
    int n;
    n = 0;
    if8.start        = 1'b1;
    if8.mode         = mode;
    if8.multiplicand = a;
    if8.multiplier   = b;
    tick();
    if8.start = 1'b0;
    while (n < 30) begin
      tick();
      n++;
      if (if8.done) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'd9);
    chk({tag, "_prod"}, 32'(if8.product), 32'(exp));
  endtask

  initial begin
    int dn;
    int first;
    int last;
    int idx;

    if4.start = 1'b0; if4.mode = 1'b0; if4.multiplicand = '0; if4.multiplier = '0;
    if8.start = 1'b0; if8.mode = 1'b0; if8.multiplicand = '0; if8.multiplier = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_prod4", 32'(if4.product), 32'd0);
    chk("rst_busy4", 32'(if4.busy), 32'd0);
    chk("rst_done4", 32'(if4.done), 32'd0);
    chk("rst_prod8", 32'(if8.product), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Unsigned exhaustive
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run4(4'(i), 4'(j), 1'b0, 8'(i * j), $sformatf("u%0d_%0d", i, j));
      end
    end

    // Signed vectors
    run4(4'h8, 4'h8, 1'b1, 8'h40, "s_m8m8");
    run4(4'hD, 4'h5, 1'b1, 8'hF1, "s_m3p5");
    run4(4'h7, 4'hF, 1'b1, 8'hF9, "s_p7m1");
    run4(4'h8, 4'h7, 1'b1, 8'hC8, "s_m8p7");
    run4(4'h0, 4'h9, 1'b1, 8'h00, "s_zero");

    // Start re-pulsed during CALC is ignored
    tick();
    tick();
    if4.start = 1'b1; if4.mode = 1'b0; if4.multiplicand = 4'd3; if4.multiplier = 4'd5;
    tick();
    if4.start = 1'b0;
    dn = 0;
    first = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (if4.done) begin
        dn++;
        if (first == 0) first = e;
      end
      if (e == 2) begin
        if4.start = 1'b1; if4.multiplicand = 4'd9; if4.multiplier = 4'd9;
      end
      if (e == 3) if4.start = 1'b0;
    end
    chk("ign_dones", 32'(dn), 32'd1);
    chk("ign_lat", 32'(first), 32'd5);
    chk("ign_prod", 32'(if4.product), 32'h0F);
    chk("ign_busy_idle", 32'(if4.busy), 32'd0);
    chk("ign_done_low", 32'(if4.done), 32'd0);

    // Reset mid-CALC
    if4.start = 1'b1; if4.multiplicand = 4'd7; if4.multiplier = 4'd7;
    tick();
    if4.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_prod", 32'(if4.product), 32'd0);
    chk("mid_rst_busy", 32'(if4.busy), 32'd0);
    chk("mid_rst_done", 32'(if4.done), 32'd0);
    tick();
    rst_n = 1'b1;
    dn = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (if4.done) dn++;
    end
    chk("mid_rst_nodone", 32'(dn), 32'd0);
    run4(4'd6, 4'd7, 1'b0, 8'h2A, "post_rst");

    // Start held high: accepted again in each DONE cycle
    tick();
    tick();
    if4.start = 1'b1; if4.mode = 1'b0;
    if4.multiplicand = hold_a[0]; if4.multiplier = hold_b[0];
    tick();
    idx = 0;
    last = 0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      if (if4.done) begin
        chk($sformatf("hold_prod%0d", idx), 32'(if4.product), 32'(hold_p[idx]));
        if (idx == 0) chk("hold_lat0", 32'(e), 32'd5);
        else chk($sformatf("hold_gap%0d", idx), 32'(e - last), 32'd6);
        last = e;
        idx++;
        if (idx < 3) begin
          if4.multiplicand = hold_a[idx]; if4.multiplier = hold_b[idx];
        end else begin
          if4.start = 1'b0;
        end
      end
    end
    chk("hold_count", 32'(idx), 32'd3);

    // 8-bit instance with signed mode disabled
    run8(8'hFF, 8'hFF, 1'b1, 16'hFE01, "w8_ff_ff");
    run8(8'h80, 8'h02, 1'b1, 16'h0100, "w8_80_02");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
